// File: rtl/instruction_fetch.sv
// Fetch front-end: issues one word index per cycle to a synchronous-read
// instruction memory and presents each returned word with its PC downstream.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    output logic [31:0]           MemAddress,
    input  logic [31:0]           MemReadData,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] Target,
    output logic [31:0]           Instr,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    output logic                  InstrValid,
    output logic [31:0]           FetchCount
);

    // Downstream handshake: a word transfers on a rising edge where
    // InstrValid=1 and Stall=0; with Stall=1 the same Instr/InstrPC is held.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pend_state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = ADDR_WIDTH'(RESET_PC);

    pend_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [ADDR_WIDTH-1:0] pend_pc, pend_pc_next;
    logic [31:0]           fetch_count, fetch_count_next;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  instr_valid;

    assign instr_valid = (state == FULL) && !Redirect;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= EMPTY;
            pc          <= RESET_PC_W;
            pend_pc     <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_pc     <= pend_pc_next;
            fetch_count <= fetch_count_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_pc_next     = pend_pc;
        fetch_count_next = fetch_count;
        addr_sel         = pc;
        if (Redirect) begin
            // The word now on MemReadData is squashed; refetch from Target.
            addr_sel     = Target;
            pend_pc_next = Target;
            state_next   = FULL;
            pc_next      = Target + ADDR_WIDTH'(1);
        end else if (Stall && state == FULL) begin
            // Re-read the held word so MemReadData stays stable next cycle.
            addr_sel = pend_pc;
        end else begin
            pend_pc_next = pc;
            state_next   = FULL;
            pc_next      = pc + ADDR_WIDTH'(1);
            if (instr_valid) begin
                fetch_count_next = fetch_count + 32'd1;
            end
        end
    end

    assign MemAddress = Reset_n ? 32'(addr_sel) : 32'(RESET_PC_W);
    assign InstrValid = instr_valid;
    assign Instr      = instr_valid ? MemReadData : 32'd0;
    assign InstrPC    = pend_pc;
    assign FetchCount = fetch_count;

endmodule
